// File: rtl/anti_theft_pkg.sv
// Shared types for the anti-theft controller: state encodings, programming
// register selectors and the alarm-event counter width.
package anti_theft_pkg;

    typedef enum logic [2:0] {
        ST_ARMED      = 3'd0,
        ST_TRIGGERED  = 3'd1,
        ST_ALARM      = 3'd2,
        ST_DISARMED   = 3'd3,
        ST_WAIT_OPEN  = 3'd4,
        ST_WAIT_CLOSE = 3'd5,
        ST_WAIT_ARM   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        SEL_ARM = 2'd0,
        SEL_DRV = 2'd1,
        SEL_PAS = 2'd2,
        SEL_ALM = 2'd3
    } prog_sel_e;

    localparam int ALARM_CNT_W = 8;

    // States that run the countdown timer; all others hold it at zero.
    function automatic logic is_timed(input state_e s);
        return (s == ST_TRIGGERED) || (s == ST_ALARM) || (s == ST_WAIT_ARM);
    endfunction

endpackage

// File: rtl/anti_theft_ctrl_if.sv
// Interval-register programming port of the anti-theft controller.
interface anti_theft_ctrl_if #(
    parameter int CNT_W = 4
);
    logic                     prog_we;
    anti_theft_pkg::prog_sel_e prog_sel;
    logic [CNT_W-1:0]         prog_val;

    modport master (output prog_we, prog_sel, prog_val);
    modport slave  (input  prog_we, prog_sel, prog_val);
endinterface

// File: rtl/tick_countdown.sv
// Tick-driven down counter: a load wins over a tick, and the count stops at
// zero, which is reported as expired.
module tick_countdown #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign expired = (count_q == '0);

endmodule

// File: rtl/anti_theft_ctrl.sv
// Anti-theft controller: door/ignition supervised arming FSM with an internal
// countdown, programmable delays, bounded siren retrigger and event counter.
module anti_theft_ctrl
    import anti_theft_pkg::*;
#(
    parameter int NUM_DOORS  = 4,
    parameter int CNT_W      = 4,
    parameter int T_ARM_DEF  = 6,
    parameter int T_DRV_DEF  = 8,
    parameter int T_PAS_DEF  = 15,
    parameter int T_ALM_DEF  = 10,
    parameter int BLINK_PER  = 3,
    parameter int MAX_RETRIG = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   ignition,
    input  logic [NUM_DOORS-1:0]   door_open,
    anti_theft_ctrl_if.slave       prog,
    output logic                   status,
    output logic                   siren,
    output logic [2:0]             state,
    output logic [CNT_W-1:0]       time_left,
    output logic [ALARM_CNT_W-1:0] alarm_count
);

    localparam int BL_W = (BLINK_PER > 1) ? $clog2(BLINK_PER) : 1;
    localparam int RT_W = (MAX_RETRIG > 0) ? $clog2(MAX_RETRIG + 1) : 1;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       intv_q [4];
    logic [CNT_W-1:0]       intv_d [4];
    logic [BL_W-1:0]        blink_q, blink_d;
    logic [RT_W-1:0]        retrig_q, retrig_d;
    logic [ALARM_CNT_W-1:0] alarm_cnt_q, alarm_cnt_d;
    logic                   siren_q, siren_d;
    logic                   status_q, status_d;

    logic                   timer_load;
    logic [CNT_W-1:0]       timer_val;
    logic [CNT_W-1:0]       timer_count;
    logic                   expired;
    logic                   any_door;
    logic                   drv_only;

    assign any_door = |door_open;
    assign drv_only = (door_open == NUM_DOORS'(1));

    tick_countdown #(.CNT_W(CNT_W)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .tick     (tick),
        .load     (timer_load),
        .load_val (timer_val),
        .count    (timer_count),
        .expired  (expired)
    );

    always_comb begin
        state_d     = state_q;
        intv_d      = intv_q;
        retrig_d    = retrig_q;
        alarm_cnt_d = alarm_cnt_q;
        timer_load  = 1'b0;
        timer_val   = '0;

        if (prog.prog_we) begin
            intv_d[prog.prog_sel] = prog.prog_val;
            state_d               = ST_ARMED;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (any_door) begin
                        state_d    = ST_TRIGGERED;
                        timer_load = 1'b1;
                        timer_val  = drv_only ? intv_q[SEL_DRV] : intv_q[SEL_PAS];
                    end else if (ignition) begin
                        state_d = ST_DISARMED;
                    end
                end
                ST_TRIGGERED: begin
                    if (ignition) begin
                        state_d = ST_DISARMED;
                    end else if (expired) begin
                        state_d    = ST_ALARM;
                        timer_load = 1'b1;
                        timer_val  = intv_q[SEL_ALM];
                        if (alarm_cnt_q != '1) begin
                            alarm_cnt_d = alarm_cnt_q + ALARM_CNT_W'(1);
                        end
                    end
                end
                ST_ALARM: begin
                    if (ignition) begin
                        state_d = ST_DISARMED;
                    end else if (expired) begin
                        if (any_door && (retrig_q < RT_W'(MAX_RETRIG))) begin
                            timer_load = 1'b1;
                            timer_val  = intv_q[SEL_ALM];
                            retrig_d   = retrig_q + RT_W'(1);
                        end else begin
                            state_d = ST_ARMED;
                        end
                    end
                end
                ST_DISARMED: begin
                    if (!ignition) state_d = ST_WAIT_OPEN;
                end
                ST_WAIT_OPEN: begin
                    if (ignition) begin
                        state_d = ST_DISARMED;
                    end else if (door_open[0]) begin
                        state_d = ST_WAIT_CLOSE;
                    end
                end
                ST_WAIT_CLOSE: begin
                    if (!door_open[0]) begin
                        state_d    = ST_WAIT_ARM;
                        timer_load = 1'b1;
                        timer_val  = intv_q[SEL_ARM];
                    end
                end
                ST_WAIT_ARM: begin
                    if (ignition) begin
                        state_d = ST_DISARMED;
                    end else if (door_open[0]) begin
                        state_d = ST_WAIT_CLOSE;
                    end else if (expired) begin
                        state_d = ST_ARMED;
                    end
                end
                default: state_d = ST_ARMED;
            endcase
        end

        // Untimed states keep the visible countdown parked at zero.
        if (!is_timed(state_d)) begin
            timer_load = 1'b1;
            timer_val  = '0;
        end

        if ((state_d != ST_ALARM) || (state_q != ST_ALARM)) begin
            retrig_d = '0;
        end

        blink_d = '0;
        if ((state_d == ST_ARMED) && (state_q == ST_ARMED)) begin
            blink_d = blink_q;
            if (tick) begin
                blink_d = (blink_q == BL_W'(BLINK_PER - 1)) ? '0 : blink_q + BL_W'(1);
            end
        end

        siren_d = (state_d == ST_ALARM);
        if (state_d == ST_ARMED) begin
            status_d = (blink_d != '0);
        end else begin
            status_d = (state_d == ST_TRIGGERED) || (state_d == ST_ALARM);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= ST_ARMED;
            // NOTE: the interval file is tiny configuration state, so unlike a RAM it is reset to its defaults.
            intv_q[SEL_ARM]  <= CNT_W'(T_ARM_DEF);
            intv_q[SEL_DRV]  <= CNT_W'(T_DRV_DEF);
            intv_q[SEL_PAS]  <= CNT_W'(T_PAS_DEF);
            intv_q[SEL_ALM]  <= CNT_W'(T_ALM_DEF);
            blink_q          <= '0;
            retrig_q         <= '0;
            alarm_cnt_q      <= '0;
            siren_q          <= 1'b0;
            status_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            intv_q           <= intv_d;
            blink_q          <= blink_d;
            retrig_q         <= retrig_d;
            alarm_cnt_q      <= alarm_cnt_d;
            siren_q          <= siren_d;
            status_q         <= status_d;
        end
    end

    assign state       = state_q;
    assign time_left   = timer_count;
    assign alarm_count = alarm_cnt_q;
    assign siren       = siren_q;
    assign status      = status_q;

endmodule

// File: tb/tb_anti_theft_ctrl.sv
// Directed scenarios with randomized tick spacing, door patterns and intervals,
// checked against tick-count arithmetic derived from the controller's rules.
module tb_anti_theft_ctrl;
    import anti_theft_pkg::*;

    localparam int NUM_DOORS = 4;
    localparam int CNT_W     = 4;
    localparam int T_ARM     = 6;
    localparam int T_DRV     = 8;
    localparam int T_PAS     = 15;
    localparam int T_ALM     = 10;
    localparam int BLINK     = 3;
    localparam int MAXR      = 2;

    localparam int S_ARMED = 0, S_TRIG = 1, S_ALARM = 2, S_DIS = 3;
    localparam int S_WOPEN = 4, S_WCLOSE = 5, S_WARM = 6;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 tick;
    logic                 ignition;
    logic [NUM_DOORS-1:0] door_open;
    logic                 status;
    logic                 siren;
    logic [2:0]           state;
    logic [CNT_W-1:0]     time_left;
    logic [7:0]           alarm_count;

    int tests = 0;
    int fails = 0;

    anti_theft_ctrl_if #(.CNT_W(CNT_W)) pif ();

    anti_theft_ctrl #(
        .NUM_DOORS  (NUM_DOORS),
        .CNT_W      (CNT_W),
        .T_ARM_DEF  (T_ARM),
        .T_DRV_DEF  (T_DRV),
        .T_PAS_DEF  (T_PAS),
        .T_ALM_DEF  (T_ALM),
        .BLINK_PER  (BLINK),
        .MAX_RETRIG (MAXR)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .tick        (tick),
        .ignition    (ignition),
        .door_open   (door_open),
        .prog        (pif.slave),
        .status      (status),
        .siren       (siren),
        .state       (state),
        .time_left   (time_left),
        .alarm_count (alarm_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: inputs change at the falling edge, outputs are sampled at the next one.
    task automatic cyc(input logic t);
        tick = t;
        @(negedge clock);
        tick = 1'b0;
    endtask

    function automatic logic exp_blink(input int ticks);
        return (ticks % BLINK) != 0;
    endfunction

    function automatic int exp_left(input int interval, input int ticks);
        return (ticks >= interval) ? 0 : interval - ticks;
    endfunction

    function automatic int sat8(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int nblink;
        int alarms;

        reset = 1'b1; tick = 1'b0; ignition = 1'b0; door_open = '0;
        pif.prog_we = 1'b0; pif.prog_sel = SEL_ARM; pif.prog_val = '0;
        alarms = 0;
        repeat (2) @(negedge clock);
        check("rst_state", state, S_ARMED);
        check("rst_status", status, 0);
        check("rst_siren", siren, 0);
        check("rst_time_left", time_left, 0);
        check("rst_alarm_count", alarm_count, 0);
        reset = 1'b0;

        // Blink pattern while armed, then at random tick spacing.
        nblink = 0;
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1); nblink++;
            check("blink", status, exp_blink(nblink));
        end
        n = $urandom_range(3, 9);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1); nblink++;
            repeat ($urandom_range(0, 2)) cyc(1'b0);
            check("blink_rand", status, exp_blink(nblink));
        end
        check("armed_state", state, S_ARMED);
        check("armed_siren", siren, 0);

        // Driver-door trigger; random door changes must not reload the timer.
        door_open = 4'b0001; cyc(1'b0);
        check("trig_state", state, S_TRIG);
        check("trig_left", time_left, T_DRV);
        check("trig_status", status, 1);
        for (int k = 1; k <= T_DRV; k++) begin
            door_open = NUM_DOORS'($urandom_range(1, 15));
            cyc(1'b1);
            check("trig_count", time_left, exp_left(T_DRV, k));
            check("trig_hold", state, S_TRIG);
            if (k < T_DRV) repeat ($urandom_range(0, 2)) cyc(1'b0);
        end
        door_open = '0; cyc(1'b0); alarms++;
        check("alarm_state", state, S_ALARM);
        check("alarm_siren", siren, 1);
        check("alarm_status", status, 1);
        check("alarm_left", time_left, T_ALM);
        check("alarm_count1", alarm_count, sat8(alarms));
        repeat (T_ALM) cyc(1'b1);
        check("alarm_last", state, S_ALARM);
        check("alarm_last_left", time_left, 0);
        cyc(1'b0);
        check("alarm_exit", state, S_ARMED);
        check("alarm_exit_siren", siren, 0);
        check("rearm_status", status, 0);

        // Passenger trigger aborted by ignition on the fifth tick.
        door_open = 4'b0101; cyc(1'b0);
        check("pas_state", state, S_TRIG);
        check("pas_left", time_left, T_PAS);
        door_open = '0;
        repeat (4) begin cyc(1'b1); cyc(1'b0); end
        check("pas_count", time_left, T_PAS - 4);
        check("pas_siren", siren, 0);
        ignition = 1'b1; cyc(1'b1);
        check("disarm_state", state, S_DIS);
        check("disarm_left", time_left, 0);
        check("disarm_status", status, 0);
        check("disarm_siren", siren, 0);
        check("disarm_count", alarm_count, sat8(alarms));

        // Exit flow, including a reopened driver door restarting the arm delay.
        ignition = 1'b0; cyc(1'b0);
        check("wait_open", state, S_WOPEN);
        door_open = 4'b0001; cyc(1'b0);
        check("wait_close", state, S_WCLOSE);
        ignition = 1'b1; cyc(1'b1);
        check("wait_close_ign", state, S_WCLOSE);
        ignition = 1'b0; door_open = '0; cyc(1'b0);
        check("wait_arm", state, S_WARM);
        check("wait_arm_left", time_left, T_ARM);
        repeat (3) cyc(1'b1);
        check("wait_arm_mid", time_left, T_ARM - 3);
        door_open = 4'b0001; cyc(1'b0);
        check("reopen_state", state, S_WCLOSE);
        check("reopen_left", time_left, 0);
        door_open = '0; cyc(1'b0);
        check("restart_left", time_left, T_ARM);
        for (int k = 1; k <= T_ARM; k++) begin
            cyc(1'b1);
            check("arm_count", time_left, exp_left(T_ARM, k));
            check("arm_hold", state, S_WARM);
        end
        cyc(1'b0);
        check("armed_again", state, S_ARMED);

        // Door held open: one siren period plus MAXR retriggers, counted once.
        door_open = 4'b0010; cyc(1'b0);
        check("hold_trig", state, S_TRIG);
        check("hold_trig_left", time_left, T_PAS);
        repeat (T_PAS) cyc(1'b1);
        cyc(1'b0); alarms++;
        check("hold_alarm", state, S_ALARM);
        for (int p = 0; p <= MAXR; p++) begin
            check("retrig_load", time_left, T_ALM);
            check("retrig_siren", siren, 1);
            repeat (T_ALM) cyc(1'b1);
            check("retrig_hold", state, S_ALARM);
            cyc(1'b0);
            if (p < MAXR) begin
                check("retrig_again", state, S_ALARM);
            end else begin
                check("retrig_done", state, S_ARMED);
                check("retrig_done_siren", siren, 0);
            end
        end
        door_open = '0;
        check("retrig_count", alarm_count, sat8(alarms));

        // Programming forces ARMED; a random driver interval is then used.
        ignition = 1'b1; cyc(1'b0);
        check("prog_pre", state, S_DIS);
        n = $urandom_range(1, 7);
        ignition = 1'b0;
        pif.prog_we = 1'b1; pif.prog_sel = SEL_DRV; pif.prog_val = CNT_W'(n);
        cyc(1'b0);
        pif.prog_we = 1'b0;
        check("prog_armed", state, S_ARMED);
        door_open = 4'b0001; cyc(1'b0);
        check("prog_trig_left", time_left, n);
        repeat (n) cyc(1'b1);
        check("prog_trig_hold", state, S_TRIG);
        cyc(1'b0); alarms++;
        check("prog_alarm", state, S_ALARM);
        repeat (3) cyc(1'b1);
        check("prog_alarm_left", time_left, T_ALM - 3);

        // Asynchronous reset in the middle of the alarm.
        reset = 1'b1;
        #1;
        check("async_siren", siren, 0);
        check("async_state", state, S_ARMED);
        check("async_left", time_left, 0);
        check("async_count", alarm_count, 0);
        check("async_status", status, 0);
        alarms = 0;
        door_open = '0;
        @(negedge clock);
        reset = 1'b0;
        door_open = 4'b0001; cyc(1'b0);
        check("default_drv", time_left, T_DRV);
        door_open = '0; ignition = 1'b1; cyc(1'b0);
        check("default_disarm", state, S_DIS);

        // Zero intervals: each timed state exits one cycle after entry.
        ignition = 1'b0;
        pif.prog_we = 1'b1; pif.prog_sel = SEL_DRV; pif.prog_val = '0; cyc(1'b0);
        pif.prog_sel = SEL_ALM; cyc(1'b0);
        pif.prog_we = 1'b0;
        door_open = 4'b0001; cyc(1'b0);
        check("zero_trig", state, S_TRIG);
        check("zero_trig_left", time_left, 0);
        door_open = '0; cyc(1'b0); alarms++;
        check("zero_alarm", state, S_ALARM);
        cyc(1'b0);
        check("zero_exit", state, S_ARMED);

        // Event counter saturation.
        for (int i = 0; i < 260; i++) begin
            door_open = 4'b0001; cyc(1'b0);
            door_open = '0; cyc(1'b0);
            cyc(1'b0);
            alarms++;
        end
        check("sat_count", alarm_count, sat8(alarms));
        check("sat_state", state, S_ARMED);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
